imem_responder: RTL and testbench
=================================

// Module: imem_responder
// PURPOSE
//  Responder side of the instruction/data memory interface used by fetch and
//  memory stages. Accepts one word request at a time (read or write), services
//  it after a fixed multi-cycle latency, then returns data with a one-cycle
//  done pulse. Holds stall while busy so the requesting stage freezes its PC.
// PARAMETERS
//  LATENCY    3   clock edges from request acceptance to done (>=1)
//  ADDR_BITS  10  word-address width; array depth = 2**ADDR_BITS 16-bit words
// PORTS
//  clk       in   1   system clock, rising edge
//  rst       in   1   asynchronous, active-high reset
//  enable    in   1   request valid; sampled only when stall=0
//  wr        in   1   1 = write, 0 = read (qualified by enable)
//  addr      in   16  byte address; word index = addr[ADDR_BITS:1]
//  data_in   in   16  write data (qualified by enable & wr)
//  data_out  out  16  read data, valid while done=1, held afterwards
//  stall     out  1   1 = busy, requests ignored
//  done      out  1   one-cycle pulse: request complete
//  err       out  1   with done: request was misaligned (addr[0]=1)
// BEHAVIOUR
//  - Reset (async, rst=1): state IDLE, count 0, data_out=0, stall=0, done=0,
//    err=0; in-flight request aborted, no write committed. Array not reset.
//  - States: IDLE, WAIT, RESP. stall = (state==WAIT); done = (state==RESP).
//  - Accept: at an edge with state!=WAIT and enable=1 -> latch addr/wr/data_in,
//    count <= LATENCY-1, state <= WAIT. Accept legal in IDLE and RESP
//    (back-to-back; one request per LATENCY+1 cycles).
//  - WAIT: at each edge, count!=0 -> count--; count==0 -> state <= RESP.
//    RESP is entered on edge T0+LATENCY, T0 = accepting edge.
//  - RESP commit (same edge that enters RESP):
//    aligned read: data_out <= array[idx]; err <= 0.
//    aligned write: array[idx] <= data; data_out unchanged; err <= 0.
//    misaligned (addr[0]=1): no array access, data_out <= 0, err <= 1.
//  - RESP, no new enable -> IDLE on next edge; done/err drop to 0.
//  - enable while stall=1: ignored, not queued; latched request unaffected by
//    input changes during WAIT.
//  - Upper addr bits [15:ADDR_BITS+1] ignored (address wraps modulo depth).
//  - Write then read of same word, back-to-back: read returns new data.
//  - Outputs registered (done/stall/err decoded from state register only).
// TESTING
//  1 Reset: rst=1 mid-WAIT of a write to 0x0010 -> outputs 0, state IDLE;
//    later read 0x0010 returns prior contents (write not committed).
//  2 Write 0xBEEF @0x0020 then read 0x0020 -> done pulses exactly on edge
//    T0+3 each time, stall=1 for 3 cycles, read data_out=0xBEEF, err=0.
//  3 Back-to-back: enable held 1 with reads of 0x0000,0x0002,0x0004 (preloaded
//    0x1111,0x2222,0x3333) -> done every 4th cycle, data in order, no drops.
//  4 Misaligned read 0x0031 -> done=1, err=1, data_out=0; array unchanged.
//  5 Enable pulsed during WAIT with other addr/data -> ignored; only original
//    request completes, one done pulse.
//  6 Wrap: write 0x5A5A @0x0800 (ADDR_BITS=10) -> read 0x0000 returns 0x5A5A;
//    repeat with LATENCY=1 -> done on first edge after accept.

Source files
------------

// File: rtl/imem_responder.sv
// Responder for the fetch/memory-stage word interface: accepts one request,
// services it after LATENCY edges, then pulses done with read data or an error.
`timescale 1ns/1ps

module imem_responder #(
   parameter int LATENCY   = 3,
   parameter int ADDR_BITS = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        wr,
   input  logic [15:0] addr,
   input  logic [15:0] data_in,
   output logic [15:0] data_out,
   output logic        stall,
   output logic        done,
   output logic        err
);

   localparam int DEPTH = 2 ** ADDR_BITS;
   localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CW-1:0] COUNT_INIT = CW'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t                 state;
   state_t                 next_state;
   logic [CW-1:0]          count;
   logic                   req_wr;
   logic                   req_odd;
   logic [ADDR_BITS-1:0]   req_idx;
   logic [15:0]            req_data;
   logic                   accept;
   logic                   commit;
   logic                   unused_upper;

   logic [15:0] mem [DEPTH];

   // Upper byte-address bits fold away so the array wraps modulo its depth.
   assign unused_upper = ^addr[15:ADDR_BITS+1];

   assign stall = (state == WAIT);
   assign done  = (state == RESP);

   always_comb begin
      accept     = (state != WAIT) && enable;
      commit     = (state == WAIT) && (count == '0);
      next_state = state;
      case (state)
         IDLE:    if (enable) next_state = WAIT;
         WAIT:    if (count == '0) next_state = RESP;
         RESP:    next_state = enable ? WAIT : IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         count    <= '0;
         req_wr   <= 1'b0;
         req_odd  <= 1'b0;
         req_idx  <= '0;
         req_data <= '0;
      end else begin
         state <= next_state;
         if (accept) begin
            count    <= COUNT_INIT;
            req_wr   <= wr;
            req_odd  <= addr[0];
            req_idx  <= addr[ADDR_BITS:1];
            req_data <= data_in;
         end else if ((state == WAIT) && (count != '0)) begin
            count <= count - CW'(1);
         end
      end
   end

   // err is only ever high while in RESP; any other edge clears it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_out <= '0;
         err      <= 1'b0;
      end else if (commit) begin
         if (req_odd) begin
            data_out <= '0;
            err      <= 1'b1;
         end else begin
            err <= 1'b0;
            if (!req_wr) data_out <= mem[req_idx];
         end
      end else begin
         err <= 1'b0;
      end
   end

   // The array has no reset; a request aborted by rst never reaches commit.
   always_ff @(posedge clk) begin
      if (commit && !req_odd && req_wr) mem[req_idx] <= req_data;
   end

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: a LATENCY=3 and a LATENCY=1 instance checked
// against a word-addressed reference memory kept in an associative array.
`timescale 1ns/1ps

module tb_imem_responder;

   logic        clk;
   logic        rst;
   logic        en      [2];
   logic        wr_s    [2];
   logic [15:0] addr_s  [2];
   logic [15:0] din_s   [2];
   logic [15:0] dout_s  [2];
   logic        stall_s [2];
   logic        done_s  [2];
   logic        err_s   [2];

   int          n_assert;
   int          n_fail;
   logic [15:0] model_mem [int];
   logic [15:0] last_dout [2];

   imem_responder #(.LATENCY(3), .ADDR_BITS(10)) dut (
      .clk(clk), .rst(rst), .enable(en[0]), .wr(wr_s[0]), .addr(addr_s[0]),
      .data_in(din_s[0]), .data_out(dout_s[0]), .stall(stall_s[0]),
      .done(done_s[0]), .err(err_s[0])
   );

   imem_responder #(.LATENCY(1), .ADDR_BITS(10)) dut_lat1 (
      .clk(clk), .rst(rst), .enable(en[1]), .wr(wr_s[1]), .addr(addr_s[1]),
      .data_in(din_s[1]), .data_out(dout_s[1]), .stall(stall_s[1]),
      .done(done_s[1]), .err(err_s[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int word_key(input int u, input logic [15:0] a);
      return u * 4096 + ((int'(a) / 2) % 1024);
   endfunction

   // Issue one request starting at a negedge where the unit is not busy.
   // junk: scribble enable/addr/data during the wait cycles.
   // keep: leave enable high at the response so the caller can chain.
   task automatic apply_stimulus(input int u, input bit w, input logic [15:0] a,
                                 input logic [15:0] d, input bit junk, input bit keep);
      int          lat;
      int          key;
      logic [15:0] exp_d;
      logic        exp_e;
      lat = (u == 0) ? 3 : 1;
      key = word_key(u, a);
      en[u] = 1'b1; wr_s[u] = w; addr_s[u] = a; din_s[u] = d;
      if (a[0]) begin
         exp_d = 16'h0000; exp_e = 1'b1;
      end else if (w) begin
         model_mem[key] = d; exp_d = last_dout[u]; exp_e = 1'b0;
      end else begin
         exp_d = model_mem.exists(key) ? model_mem[key] : 16'hxxxx; exp_e = 1'b0;
      end
      last_dout[u] = exp_d;
      @(posedge clk);
      for (int k = 0; k < lat; k++) begin
         @(negedge clk);
         check_output($sformatf("u%0d stall_wait%0d a=%h", u, k, a), {15'b0, stall_s[u]}, 16'h1);
         check_output($sformatf("u%0d done_wait%0d a=%h", u, k, a), {15'b0, done_s[u]}, 16'h0);
         if (junk) begin
            en[u]     = 1'($urandom_range(0, 1));
            wr_s[u]   = 1'($urandom_range(0, 1));
            addr_s[u] = 16'($urandom);
            din_s[u]  = 16'($urandom);
         end else if (!keep) begin
            en[u] = 1'b0;
         end
      end
      @(negedge clk);
      check_output($sformatf("u%0d done_resp a=%h", u, a), {15'b0, done_s[u]}, 16'h1);
      check_output($sformatf("u%0d stall_resp a=%h", u, a), {15'b0, stall_s[u]}, 16'h0);
      check_output($sformatf("u%0d err_resp a=%h", u, a), {15'b0, err_s[u]}, {15'b0, exp_e});
      check_output($sformatf("u%0d data_resp a=%h", u, a), dout_s[u], exp_d);
      if (!keep) begin
         en[u] = 1'b0;
         @(negedge clk);
         check_output($sformatf("u%0d done_after a=%h", u, a), {15'b0, done_s[u]}, 16'h0);
         check_output($sformatf("u%0d stall_after a=%h", u, a), {15'b0, stall_s[u]}, 16'h0);
         check_output($sformatf("u%0d err_after a=%h", u, a), {15'b0, err_s[u]}, 16'h0);
         check_output($sformatf("u%0d data_held a=%h", u, a), dout_s[u], exp_d);
      end
   endtask

   initial begin
      logic [15:0] ra;
      bit          rw;
      n_assert = 0;
      n_fail   = 0;
      for (int u = 0; u < 2; u++) begin
         en[u] = 1'b0; wr_s[u] = 1'b0; addr_s[u] = '0; din_s[u] = '0;
         last_dout[u] = '0;
      end

      // Power-on reset
      rst = 1'b1;
      #1;
      for (int u = 0; u < 2; u++) begin
         check_output($sformatf("u%0d reset_data", u), dout_s[u], 16'h0);
         check_output($sformatf("u%0d reset_stall", u), {15'b0, stall_s[u]}, 16'h0);
         check_output($sformatf("u%0d reset_done", u), {15'b0, done_s[u]}, 16'h0);
         check_output($sformatf("u%0d reset_err", u), {15'b0, err_s[u]}, 16'h0);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Reset in the middle of a write must abort it
      apply_stimulus(0, 1'b1, 16'h0010, 16'h1234, 1'b0, 1'b0);
      apply_stimulus(0, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0);
      en[0] = 1'b1; wr_s[0] = 1'b1; addr_s[0] = 16'h0010; din_s[0] = 16'hDEAD;
      @(posedge clk);
      @(negedge clk);
      check_output("abort_stall_before_rst", {15'b0, stall_s[0]}, 16'h1);
      en[0] = 1'b0;
      rst = 1'b1;
      #1;
      check_output("abort_data", dout_s[0], 16'h0);
      check_output("abort_stall", {15'b0, stall_s[0]}, 16'h0);
      check_output("abort_done", {15'b0, done_s[0]}, 16'h0);
      check_output("abort_err", {15'b0, err_s[0]}, 16'h0);
      last_dout[0] = '0;
      last_dout[1] = '0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_output("abort_idle_stall", {15'b0, stall_s[0]}, 16'h0);
      apply_stimulus(0, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0);

      // Write then read back
      apply_stimulus(0, 1'b1, 16'h0020, 16'hBEEF, 1'b0, 1'b0);
      apply_stimulus(0, 1'b0, 16'h0020, 16'h0000, 1'b0, 1'b0);

      // Back-to-back reads with enable held high
      apply_stimulus(0, 1'b1, 16'h0000, 16'h1111, 1'b0, 1'b0);
      apply_stimulus(0, 1'b1, 16'h0002, 16'h2222, 1'b0, 1'b0);
      apply_stimulus(0, 1'b1, 16'h0004, 16'h3333, 1'b0, 1'b0);
      apply_stimulus(0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
      apply_stimulus(0, 1'b0, 16'h0002, 16'h0000, 1'b0, 1'b1);
      apply_stimulus(0, 1'b0, 16'h0004, 16'h0000, 1'b0, 1'b0);

      // Back-to-back write then read of the same word
      apply_stimulus(0, 1'b1, 16'h0006, 16'hC0DE, 1'b0, 1'b1);
      apply_stimulus(0, 1'b0, 16'h0006, 16'h0000, 1'b0, 1'b0);

      // Misaligned access leaves the array alone
      apply_stimulus(0, 1'b1, 16'h0030, 16'hA5A5, 1'b0, 1'b0);
      apply_stimulus(0, 1'b0, 16'h0031, 16'h0000, 1'b0, 1'b0);
      apply_stimulus(0, 1'b1, 16'h0031, 16'hFFFF, 1'b0, 1'b0);
      apply_stimulus(0, 1'b0, 16'h0030, 16'h0000, 1'b0, 1'b0);

      // Requests during the busy window are dropped
      apply_stimulus(0, 1'b1, 16'h0040, 16'h7777, 1'b1, 1'b0);
      apply_stimulus(0, 1'b0, 16'h0040, 16'h0000, 1'b1, 1'b0);

      // Address wrap on both latencies
      apply_stimulus(0, 1'b1, 16'h0800, 16'h5A5A, 1'b0, 1'b0);
      apply_stimulus(0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
      apply_stimulus(1, 1'b1, 16'h0800, 16'h5A5A, 1'b0, 1'b0);
      apply_stimulus(1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);

      // Randomized traffic over a small word pool with random upper bits
      for (int u = 0; u < 2; u++) begin
         for (int n = 0; n < 40; n++) begin
            ra = {5'($urandom), 7'd0, 3'($urandom_range(0, 7)), 1'b0};
            if ($urandom_range(0, 7) == 0) ra[0] = 1'b1;
            rw = 1'($urandom_range(0, 1));
            if (!rw && !ra[0] && !model_mem.exists(word_key(u, ra))) rw = 1'b1;
            apply_stimulus(u, rw, ra, 16'($urandom), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)));
         end
         en[u] = 1'b0;
         @(negedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
